// File: rtl/cus19_pc_ctrl.sv
// Control-flow sequencer for the Custom19 PC: one registered PC command per accepted instruction.
// Optional interrupt entry path is enabled by defining CUS19_IRQ_EN.
module cus19_pc_ctrl #(
  parameter int                  PC_Width    = 11,
  parameter int                  Stack_Depth = 8,
  parameter logic [PC_Width-1:0] IRQ_Vector  = 11'h7F0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           instr_valid_in,
  input  logic [2:0]                     op_class_in,
  input  logic                           cond_in,
  input  logic [PC_Width-1:0]            imm_addr_in,
  input  logic                           stall_in,
  input  logic                           irq_in,
  output logic [2:0]                     pc_src_out,
  output logic                           pc_en_out,
  output logic [PC_Width-1:0]            imm_addr_out,
  output logic                           flush_out,
  output logic                           halted_out,
  output logic [$clog2(Stack_Depth):0]   stack_cnt_out,
  output logic                           stack_fault_out,
  output logic                           irq_ack_out
);
  localparam int CNT_W = $clog2(Stack_Depth) + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(Stack_Depth);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  localparam logic [2:0] SRC_INC  = 3'b000;
  localparam logic [2:0] SRC_BR   = 3'b001;
  localparam logic [2:0] SRC_JMP  = 3'b010;
  localparam logic [2:0] SRC_CALL = 3'b011;
  localparam logic [2:0] SRC_RET  = 3'b100;

  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [1:0] {RUN, FLUSH, HALT, FAULT} state_t;
  state_t state;

`ifdef CUS19_IRQ_EN
  logic             in_isr;
  logic [CNT_W-1:0] isr_cnt;
  logic             irq_take;
  assign irq_take = irq_in && !in_isr;
`else
  localparam logic [PC_Width-1:0] unused_vector = IRQ_Vector;
  logic unused_irq;
  assign unused_irq  = irq_in;
  assign irq_ack_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      pc_src_out      <= SRC_INC;
      pc_en_out       <= 1'b0;
      imm_addr_out    <= '0;
      flush_out       <= 1'b0;
      halted_out      <= 1'b0;
      stack_cnt_out   <= '0;
      stack_fault_out <= 1'b0;
`ifdef CUS19_IRQ_EN
      irq_ack_out     <= 1'b0;
      in_isr          <= 1'b0;
      isr_cnt         <= '0;
`endif
    end else begin
      // Command outputs are single-cycle strobes; imm_addr_out alone holds.
      pc_src_out <= SRC_INC;
      pc_en_out  <= 1'b0;
      flush_out  <= 1'b0;
`ifdef CUS19_IRQ_EN
      irq_ack_out <= 1'b0;
`endif
      case (state)
        RUN: begin
          if (!stall_in) begin
`ifdef CUS19_IRQ_EN
            if (irq_take) begin
              if (stack_cnt_out == DEPTH) begin
                stack_fault_out <= 1'b1;
                state           <= FAULT;
              end else begin
                pc_en_out     <= 1'b1;
                pc_src_out    <= SRC_CALL;
                imm_addr_out  <= IRQ_Vector;
                flush_out     <= 1'b1;
                irq_ack_out   <= 1'b1;
                in_isr        <= 1'b1;
                isr_cnt       <= stack_cnt_out;
                stack_cnt_out <= stack_cnt_out + ONE;
                state         <= FLUSH;
              end
            end else
`endif
            if (instr_valid_in) begin
              case (op_class_in)
                OP_BR: begin
                  pc_en_out    <= 1'b1;
                  imm_addr_out <= imm_addr_in;
                  if (cond_in) begin
                    pc_src_out <= SRC_BR;
                    flush_out  <= 1'b1;
                    state      <= FLUSH;
                  end
                end
                OP_JMP: begin
                  pc_en_out    <= 1'b1;
                  pc_src_out   <= SRC_JMP;
                  imm_addr_out <= imm_addr_in;
                  flush_out    <= 1'b1;
                  state        <= FLUSH;
                end
                OP_CALL: begin
                  if (stack_cnt_out == DEPTH) begin
                    stack_fault_out <= 1'b1;
                    state           <= FAULT;
                  end else begin
                    pc_en_out     <= 1'b1;
                    pc_src_out    <= SRC_CALL;
                    imm_addr_out  <= imm_addr_in;
                    flush_out     <= 1'b1;
                    stack_cnt_out <= stack_cnt_out + ONE;
                    state         <= FLUSH;
                  end
                end
                OP_RET: begin
                  if (stack_cnt_out == '0) begin
                    stack_fault_out <= 1'b1;
                    state           <= FAULT;
                  end else begin
                    pc_en_out     <= 1'b1;
                    pc_src_out    <= SRC_RET;
                    imm_addr_out  <= imm_addr_in;
                    flush_out     <= 1'b1;
                    stack_cnt_out <= stack_cnt_out - ONE;
                    state         <= FLUSH;
`ifdef CUS19_IRQ_EN
                    // Leaving the ISR: the stack is back at its entry depth.
                    if (in_isr && (stack_cnt_out - ONE) == isr_cnt) in_isr <= 1'b0;
`endif
                  end
                end
                OP_HALT: begin
                  halted_out <= 1'b1;
                  state      <= HALT;
                end
                default: begin
                  pc_en_out    <= 1'b1;
                  imm_addr_out <= imm_addr_in;
                end
              endcase
            end
          end
        end
        FLUSH: state <= RUN;
        HALT: begin
`ifdef CUS19_IRQ_EN
          // Wake to RUN; the level irq is taken there on the next cycle.
          if (irq_take) begin
            halted_out <= 1'b0;
            state      <= RUN;
          end
`endif
        end
        default: state <= FAULT;
      endcase
    end
  end
endmodule

// File: tb/tb_cus19_pc_ctrl.sv
// Bench for cus19_pc_ctrl: directed vector table, hand-written multi-cycle sequences,
// then random stimulus against a flag-based reference model.
module tb_cus19_pc_ctrl;
  logic        clk = 1'b0;
  logic        rst, valid, cond, stall, irq;
  logic [2:0]  op;
  logic [10:0] imm;
  logic [2:0]  pc_src;
  logic        pc_en, flush, halted, fault, ack;
  logic [10:0] imm_o;
  logic [3:0]  cnt;

  int checks = 0;
  int errors = 0;

`ifdef CUS19_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  cus19_pc_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid_in(valid), .op_class_in(op), .cond_in(cond),
    .imm_addr_in(imm), .stall_in(stall), .irq_in(irq), .pc_src_out(pc_src),
    .pc_en_out(pc_en), .imm_addr_out(imm_o), .flush_out(flush), .halted_out(halted),
    .stack_cnt_out(cnt), .stack_fault_out(fault), .irq_ack_out(ack)
  );

  typedef struct {
    logic rst, v; logic [2:0] op; logic c; logic [10:0] imm; logic st;
    logic en; logic [2:0] src; logic [10:0] eimm; logic fl, hlt; logic [3:0] cnt; logic flt;
  } vec_t;
  vec_t tbl[23];

  // Reference model state
  int          m_cnt, m_isr_cnt;
  bit          m_flushp, m_halt, m_fault, m_in_isr;
  bit          e_en, e_fl, e_ack;
  logic [2:0]  e_src;
  logic [10:0] e_imm;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(string t, bit en, logic [2:0] src, logic [10:0] a, bit fl,
                           bit hlt, logic [3:0] c, bit flt, bit ak);
    chk({t, ".en"}, 32'(pc_en), 32'(en));
    chk({t, ".src"}, 32'(pc_src), 32'(src));
    chk({t, ".imm"}, 32'(imm_o), 32'(a));
    chk({t, ".flush"}, 32'(flush), 32'(fl));
    chk({t, ".halted"}, 32'(halted), 32'(hlt));
    chk({t, ".cnt"}, 32'(cnt), 32'(c));
    chk({t, ".fault"}, 32'(fault), 32'(flt));
    chk({t, ".ack"}, 32'(ack), 32'(ak));
  endtask

  task automatic cycle(bit r, bit v, logic [2:0] o, bit c, logic [10:0] a, bit s, bit q);
    rst = r; valid = v; op = o; cond = c; imm = a; stall = s; irq = q;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [2:0] s, logic [10:0] a);
    e_en = 1'b1; e_src = s; e_imm = a;
    if (s != 3'b000) begin e_fl = 1'b1; m_flushp = 1'b1; end
  endtask

  // Expected outputs after one clock, derived from the control-flow rules.
  task automatic model_step(bit r, bit v, logic [2:0] o, bit c, logic [10:0] a, bit s, bit q);
    e_en = 0; e_src = 3'b000; e_fl = 0; e_ack = 0;
    if (r) begin
      m_cnt = 0; m_flushp = 0; m_halt = 0; m_fault = 0; m_in_isr = 0; e_imm = '0;
      return;
    end
    if (m_fault) return;
    if (m_halt) begin
      if (IRQ_ON && q && !m_in_isr) m_halt = 0;
      return;
    end
    if (m_flushp) begin m_flushp = 0; return; end
    if (s) return;
    if (IRQ_ON && q && !m_in_isr) begin
      if (m_cnt == 8) m_fault = 1;
      else begin
        m_isr_cnt = m_cnt; m_cnt++; m_in_isr = 1; e_ack = 1; issue(3'b011, 11'h7F0);
      end
      return;
    end
    if (!v) return;
    case (o)
      3'd1: issue(c ? 3'b001 : 3'b000, a);
      3'd2: issue(3'b010, a);
      3'd3: if (m_cnt == 8) m_fault = 1; else begin m_cnt++; issue(3'b011, a); end
      3'd4: if (m_cnt == 0) m_fault = 1;
            else begin
              m_cnt--; issue(3'b100, a);
              if (m_in_isr && m_cnt == m_isr_cnt) m_in_isr = 0;
            end
      3'd5: m_halt = 1;
      default: issue(3'b000, a);
    endcase
  endtask

  initial begin
    rst = 1; valid = 0; op = 0; cond = 0; imm = 0; stall = 0; irq = 0;
    //          rst v  op c imm  st   en src eimm fl hlt cnt flt
    tbl[0]  = '{1, 0, 0, 0, 0,  0,   0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 3,  0,   1, 0, 3,  0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 4,  0,   1, 0, 4,  0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 6,  0,   1, 0, 6,  0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 1, 5,  0,   1, 1, 5,  1, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 9,  0,   0, 0, 5,  0, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 7,  0,   1, 0, 7,  0, 0, 0, 0};
    tbl[7]  = '{0, 1, 2, 0, 2,  0,   1, 2, 2,  1, 0, 0, 0};
    tbl[8]  = '{0, 1, 3, 0, 10, 0,   0, 0, 2,  0, 0, 0, 0};
    tbl[9]  = '{0, 1, 3, 0, 10, 0,   1, 3, 10, 1, 0, 1, 0};
    tbl[10] = '{0, 1, 4, 0, 0,  0,   0, 0, 10, 0, 0, 1, 0};
    tbl[11] = '{0, 1, 4, 0, 0,  0,   1, 4, 0,  1, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 8,  0,   0, 0, 0,  0, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 1,  1,   0, 0, 0,  0, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 1,  1,   0, 0, 0,  0, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 1,  1,   0, 0, 0,  0, 0, 0, 0};
    tbl[16] = '{0, 1, 0, 0, 1,  0,   1, 0, 1,  0, 0, 0, 0};
    tbl[17] = '{0, 1, 4, 0, 0,  0,   0, 0, 1,  0, 0, 0, 1};
    tbl[18] = '{0, 1, 0, 0, 2,  0,   0, 0, 1,  0, 0, 0, 1};
    tbl[19] = '{1, 0, 0, 0, 0,  0,   0, 0, 0,  0, 0, 0, 0};
    tbl[20] = '{0, 1, 5, 0, 4,  0,   0, 0, 0,  0, 1, 0, 0};
    tbl[21] = '{0, 1, 0, 0, 3,  0,   0, 0, 0,  0, 1, 0, 0};
    tbl[22] = '{1, 0, 0, 0, 0,  0,   0, 0, 0,  0, 0, 0, 0};

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].op, tbl[i].c, tbl[i].imm, tbl[i].st, 1'b0);
      check_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].src, tbl[i].eimm, tbl[i].fl,
                tbl[i].hlt, tbl[i].cnt, tbl[i].flt, 1'b0);
    end

    // Fill the return stack, then overflow it.
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 3'd3, 0, 11'(20 + i), 0, 0);
      check_out($sformatf("call%0d", i), 1, 3'b011, 11'(20 + i), 1, 0, 4'(i + 1), 0, 0);
      cycle(0, 0, 3'd0, 0, 0, 0, 0);
      check_out($sformatf("callgap%0d", i), 0, 3'b000, 11'(20 + i), 0, 0, 4'(i + 1), 0, 0);
    end
    cycle(0, 1, 3'd3, 0, 11'd99, 0, 0);
    check_out("overflow", 0, 3'b000, 11'd27, 0, 0, 4'd8, 1, 0);
    cycle(0, 1, 3'd0, 0, 11'd98, 0, 0);
    check_out("fault_hold", 0, 3'b000, 11'd27, 0, 0, 4'd8, 1, 0);
    cycle(1, 0, 3'd0, 0, 0, 0, 0);
    check_out("fault_rst", 0, 3'b000, 11'd0, 0, 0, 4'd0, 0, 0);

`ifdef CUS19_IRQ_EN
    cycle(0, 1, 3'd2, 0, 11'd2, 0, 1);
    check_out("irq_take", 1, 3'b011, 11'h7F0, 1, 0, 4'd1, 0, 1);
    cycle(0, 1, 3'd2, 0, 11'd2, 0, 1);
    check_out("irq_flush", 0, 3'b000, 11'h7F0, 0, 0, 4'd1, 0, 0);
    cycle(0, 1, 3'd0, 0, 11'd4, 0, 1);
    check_out("irq_masked", 1, 3'b000, 11'd4, 0, 0, 4'd1, 0, 0);
    cycle(0, 1, 3'd4, 0, 11'd5, 0, 1);
    check_out("irq_ret", 1, 3'b100, 11'd5, 1, 0, 4'd0, 0, 0);
    cycle(0, 0, 3'd0, 0, 0, 0, 1);
    check_out("irq_retflush", 0, 3'b000, 11'd5, 0, 0, 4'd0, 0, 0);
    cycle(0, 1, 3'd0, 0, 11'd6, 0, 1);
    check_out("irq_again", 1, 3'b011, 11'h7F0, 1, 0, 4'd1, 0, 1);
    cycle(1, 0, 3'd0, 0, 0, 0, 0);
    check_out("irq_rst", 0, 3'b000, 11'd0, 0, 0, 4'd0, 0, 0);
`endif

    // Random traffic against the reference model.
    model_step(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      automatic int r = $urandom_range(0, 99);
      automatic logic [2:0] o;
      automatic bit rr = ($urandom_range(0, 99) < 3);
      automatic bit vv = ($urandom_range(0, 9) < 8);
      automatic bit cc = $urandom_range(0, 1);
      automatic bit ss = ($urandom_range(0, 9) == 0);
      automatic bit qq = ($urandom_range(0, 19) == 0);
      automatic logic [10:0] aa = 11'($urandom);
      if (r < 35) o = 3'd0;
      else if (r < 50) o = 3'd1;
      else if (r < 60) o = 3'd2;
      else if (r < 75) o = 3'd3;
      else if (r < 90) o = 3'd4;
      else if (r < 92) o = 3'd5;
      else o = 3'($urandom_range(6, 7));
      model_step(rr, vv, o, cc, aa, ss, qq);
      cycle(rr, vv, o, cc, aa, ss, qq);
      check_out($sformatf("rnd%0d", n), e_en, e_src, e_imm, e_fl, m_halt, 4'(m_cnt),
                m_fault, e_ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cus19_pc_ctrl.md
# cus19_pc_ctrl

Control-flow sequencer for the Custom19 program counter. Accepts decoded control-flow class, condition and target from decode and issues one registered PC command (pc source select, enable, target) per instruction to `cus19_pc`. It also flushes wrong-path fetch, mirrors call-stack occupancy, and traps on stack overflow/underflow. An optional interrupt path forces a call to a fixed vector.

## Interface
- `PC_Width`, 11, PC and target width
- `Stack_Depth`, 8, return-stack entries in `cus19_pc`; overflow/underflow limit
- `IRQ_Vector`, 11'h7F0, interrupt target address (used only with `CUS19_IRQ_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr_valid_in`  in  1  decode holds an instruction this cycle
- `op_class_in`  in  3  000 seq, 001 cond branch, 010 jump, 011 call, 100 ret, 101 halt; 110/111 treated as seq
- `cond_in`  in  1  branch condition true (used only for 001)
- `imm_addr_in`  in  PC_Width  branch/jump/call target
- `stall_in`  in  1  pipeline stall; blocks acceptance
- `irq_in`  in  1  interrupt request, level
- `pc_src_out`  out  3  to `cus19_pc` select: 000 +1, 001 branch, 010 jump, 011 call, 100 return
- `pc_en_out`  out  1  PC update strobe
- `imm_addr_out`  out  PC_Width  registered target
- `flush_out`  out  1  kill the fetched wrong-path instruction
- `halted_out`  out  1  core halted
- `stack_cnt_out`  out  $clog2(Stack_Depth)+1  return-stack occupancy
- `stack_fault_out`  out  1  sticky overflow/underflow trap
- `irq_ack_out`  out  1  one-cycle interrupt acceptance pulse

## Operation
- States: RUN, FLUSH, HALT, FAULT. Reset enters RUN.
- Accept when state == RUN, `instr_valid_in` = 1 and `stall_in` = 0.
- On accept, decode and register the command:
  - seq or branch not-taken: src 000.
  - branch taken: 001. jump: 010. call: 011. ret: 100.
- `pc_en_out` = 1 for exactly one cycle per accepted instruction. In all other cycles it is 0 and src is 000.
- Taken flow (branch taken, jump, call, ret):
  - `flush_out` = 1 in the issue cycle.
  - State goes to FLUSH for one cycle, during which nothing is accepted.
  - Then RUN.
- Call: `stack_cnt` +1. Ret: `stack_cnt` −1.
- Call with cnt == Stack_Depth, or ret with cnt == 0:
  - no issue, cnt unchanged.
  - `stack_fault_out` = 1, state FAULT.
  - FAULT is left only by `rst`.
- Halt: no issue; `halted_out` = 1, state HALT.
- HALT and FAULT: `pc_en_out` = 0 and `flush_out` = 0 continuously.
- Reset mid-operation overrides everything on the next edge.

## Timing
- Latency: command outputs valid the cycle after acceptance (1-cycle registered).
- Max issue rate: 1 per cycle for sequential code; 1 per 2 cycles for taken flow.
- `imm_addr_out` holds its last value when not issuing.
- Reset values:
  - `pc_src_out` 000, `pc_en_out` 0, `imm_addr_out` 0, `flush_out` 0.
  - `halted_out` 0, `stack_cnt_out` 0, `stack_fault_out` 0, `irq_ack_out` 0.
- Stall in RUN: no accept, no state change, no counter change.

## Configuration
- `CUS19_IRQ_EN` defined:
  - In RUN with `stall_in` = 0, `irq_in` = 1 and not in-ISR, the interrupt wins over any valid instruction (that instruction is not accepted).
  - Issues src 011 with `imm_addr_out` = `IRQ_Vector`, `irq_ack_out` = 1, `flush_out` = 1, cnt +1, then FLUSH.
  - Sets in-ISR and records entry cnt. In-ISR clears on the ret that returns cnt to that entry value.
  - While in-ISR, `irq_in` is ignored.
  - `irq_in` in HALT clears `halted_out` and takes the interrupt next cycle.
  - IRQ with cnt == Stack_Depth is a fault.
- `CUS19_IRQ_EN` undefined: `irq_in` is ignored and `irq_ack_out` is tied 0.

## Test plan
- Reset, then 3 seq instructions → 3 consecutive `pc_en_out` pulses with src 000; flush never asserts.
- Branch, `cond_in` = 1, imm 5 → next cycle src 001, imm 5, flush 1. The following valid is refused for 1 cycle. With `cond_in` = 0 → src 000, no flush.
- Jump to imm 2, then call to imm 10, then ret:
  - src 010, 011, 100, each followed by one FLUSH cycle.
  - cnt 0→1→0.
- 8 calls, then a 9th call → cnt 8, then `stack_fault_out` = 1, no `pc_en_out`. Subsequent valids are ignored until `rst`.
- Ret at cnt 0 → fault. Halt → `halted_out` = 1 with no further issue. `stall_in` held 3 cycles → no accept.
- With `CUS19_IRQ_EN`: `irq_in` at the same cycle as a valid jump → src 011, imm 7F0, `irq_ack_out` pulse, cnt +1. A second IRQ is ignored until the matching ret.
